// File: rtl/sgd_loss_gradient_unit.sv
// Join point between the dot-product engines and the model-update stage: buffers partial sums and
// labels, reduces over engines and emits the step-scaled, saturated loss gradient per bank.
module sgd_loss_gradient_unit #(
  parameter int NUM_BANKS       = 8,
  parameter int ENGINE_NUM      = 4,
  parameter int DW              = 32,
  parameter int FRAC            = 24,
  parameter int FIFO_DEPTH_BITS = 6,
  parameter int AF_MARGIN       = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [4:0]                         cfg_shift,
  input  logic [1:0]                         cfg_mode,
  input  logic                               cfg_round,
  input  logic [ENGINE_NUM*NUM_BANKS*DW-1:0] dot_data,
  input  logic [ENGINE_NUM-1:0]              dot_valid,
  output logic [ENGINE_NUM-1:0]              dot_almost_full,
  input  logic [NUM_BANKS*DW-1:0]            b_data,
  input  logic                               b_wr_en,
  output logic                               b_almost_full,
  output logic [NUM_BANKS*DW-1:0]            grad_data,
  output logic                               grad_valid,
  output logic [31:0]                        sample_cnt,
  output logic                               err_overflow
);

  localparam int L     = $clog2(ENGINE_NUM);
  localparam int SW    = DW + L;
  localparam int GW    = SW + 1;
  localparam int BV    = NUM_BANKS * DW;
  localparam int NF    = ENGINE_NUM + 1;
  localparam int PW    = FIFO_DEPTH_BITS;
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;

  localparam logic [PW:0]          DEPTH_C  = (PW+1)'(DEPTH);
  localparam logic [PW:0]          AF_LEVEL = (PW+1)'(DEPTH - AF_MARGIN);
  localparam logic signed [GW-1:0] ONE      = GW'(1) << FRAC;
  localparam logic signed [GW:0]   SAT_HI   = {{(GW-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [GW:0]   SAT_LO   = ~SAT_HI;

  typedef enum logic [1:0] {
    MODE_LSQ   = 2'd0,
    MODE_HINGE = 2'd1,
    MODE_L1    = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_t;

  // ---------------- input FIFOs (engines 0..ENGINE_NUM-1, then labels) ----------------
  logic [NF-1:0] fifo_wr, fifo_full, fifo_nonempty, fifo_af;
  logic [BV-1:0] fifo_wdata [NF];
  logic [BV-1:0] fifo_rdata [NF];
  logic          pop;

  assign fifo_wr = {b_wr_en, dot_valid};
  for (genvar e = 0; e < ENGINE_NUM; e++) begin : g_wsel
    assign fifo_wdata[e] = dot_data[e*BV +: BV];
  end
  assign fifo_wdata[ENGINE_NUM] = b_data;

  for (genvar f = 0; f < NF; f++) begin : g_fifo
    logic [BV-1:0] mem [DEPTH];
    logic [BV-1:0] rdata;
    logic [PW-1:0] wp, rp;
    logic [PW:0]   cnt;
    logic          wr_ok;

    assign wr_ok            = fifo_wr[f] && !fifo_full[f];
    assign fifo_full[f]     = (cnt == DEPTH_C);
    assign fifo_nonempty[f] = (cnt != '0);
    assign fifo_af[f]       = (cnt >= AF_LEVEL);
    assign fifo_rdata[f]    = rdata;

    always_ff @(posedge clk) begin
      if (wr_ok) mem[wp] <= fifo_wdata[f];
      if (pop)   rdata   <= mem[rp];
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (wr_ok) wp <= wp + 1'b1;
        if (pop)   rp <= rp + 1'b1;
        cnt <= cnt + {{PW{1'b0}}, wr_ok} - {{PW{1'b0}}, pop};
      end
    end
  end

  assign pop             = &fifo_nonempty;
  assign dot_almost_full = fifo_af[ENGINE_NUM-1:0];
  assign b_almost_full   = fifo_af[ENGINE_NUM];

  always_ff @(posedge clk) begin
    if (!rst_n)                         err_overflow <= 1'b0;
    else if (|(fifo_wr & fifo_full))    err_overflow <= 1'b1;
  end

  // ---------------- pipeline control: R, T1..TL, D, M ----------------
  logic          r_valid, d_valid, m_valid;
  logic [L-1:0]  t_valid;
  logic [4:0]    r_shift, d_shift, m_shift;
  logic          r_round, d_round, m_round;
  mode_t         r_mode, d_mode;
  logic [BV-1:0] t_b     [L];
  logic [4:0]    t_shift [L];
  mode_t         t_mode  [L];
  logic          t_round [L];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      t_valid <= '0;
      d_valid <= 1'b0;
      m_valid <= 1'b0;
    end else begin
      r_valid    <= pop;
      t_valid[0] <= r_valid;
      for (int unsigned i = 1; i < L; i++) t_valid[i] <= t_valid[i-1];
      d_valid    <= t_valid[L-1];
      m_valid    <= d_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      r_shift <= cfg_shift;
      r_mode  <= mode_t'(cfg_mode);
      r_round <= cfg_round;
    end
    t_b[0]     <= fifo_rdata[ENGINE_NUM];
    t_shift[0] <= r_shift;
    t_mode[0]  <= r_mode;
    t_round[0] <= r_round;
    for (int unsigned i = 1; i < L; i++) begin
      t_b[i]     <= t_b[i-1];
      t_shift[i] <= t_shift[i-1];
      t_mode[i]  <= t_mode[i-1];
      t_round[i] <= t_round[i-1];
    end
  end

  // Adder tree: level 0 is the FIFO read register, each further level is a registered stage
  for (genvar l = 0; l <= L; l++) begin : lvl
    localparam int N = ENGINE_NUM >> l;
    localparam int W = DW + l;
    logic signed [W-1:0] s [N][NUM_BANKS];

    if (l == 0) begin : g_leaf
      for (genvar e = 0; e < ENGINE_NUM; e++) begin : g_e
        for (genvar n = 0; n < NUM_BANKS; n++) begin : g_n
          assign s[e][n] = fifo_rdata[e][n*DW +: DW];
        end
      end
    end else begin : g_add
      always_ff @(posedge clk) begin
        for (int unsigned e = 0; e < N; e++)
          for (int unsigned n = 0; n < NUM_BANKS; n++)
            s[e][n] <= W'(lvl[l-1].s[2*e][n]) + W'(lvl[l-1].s[2*e+1][n]);
      end
    end
  end

  // ---------------- stage D: exact residual ----------------
  logic signed [SW-1:0] d_sum [NUM_BANKS];
  logic signed [DW-1:0] d_b   [NUM_BANKS];
  logic signed [GW-1:0] d_d   [NUM_BANKS];

  always_ff @(posedge clk) begin
    for (int unsigned n = 0; n < NUM_BANKS; n++) begin
      d_sum[n] <= lvl[L].s[0][n];
      d_b[n]   <= t_b[L-1][n*DW +: DW];
      d_d[n]   <= GW'(lvl[L].s[0][n]) - GW'(signed'(t_b[L-1][n*DW +: DW]));
    end
    d_shift <= t_shift[L-1];
    d_mode  <= t_mode[L-1];
    d_round <= t_round[L-1];
  end

  // ---------------- stage M: loss-specific gradient ----------------
  function automatic logic signed [GW-1:0] loss_grad(input mode_t mode,
                                                     input logic signed [SW-1:0] sum,
                                                     input logic signed [DW-1:0] b,
                                                     input logic signed [GW-1:0] d);
    logic signed [GW-1:0] margin;
    margin = b[DW-1] ? -GW'(sum) : GW'(sum);
    case (mode)
      MODE_HINGE: loss_grad = (margin < ONE) ? -GW'(b) : '0;
      MODE_L1:    loss_grad = d[GW-1] ? -ONE : ((d != '0) ? ONE : '0);
      default:    loss_grad = d;
    endcase
  endfunction

  logic signed [GW-1:0] m_next [NUM_BANKS];
  logic signed [GW-1:0] m_g    [NUM_BANKS];

  always_comb begin
    for (int unsigned n = 0; n < NUM_BANKS; n++) m_next[n] = '0;
    for (int unsigned n = 0; n < NUM_BANKS; n++)
      m_next[n] = loss_grad(d_mode, d_sum[n], d_b[n], d_d[n]);
  end

  always_ff @(posedge clk) begin
    for (int unsigned n = 0; n < NUM_BANKS; n++) m_g[n] <= m_next[n];
    m_shift <= d_shift;
    m_round <= d_round;
  end

  // ---------------- stage S: step-size scaling and saturation ----------------
  function automatic logic [DW-1:0] scale(input logic signed [GW-1:0] g,
                                          input logic [4:0] sh,
                                          input logic rnd);
    logic signed [GW:0] t;
    t = (GW+1)'(g);
    if (rnd && (sh != 5'd0)) t = t + ((GW+1)'(1) << (sh - 5'd1));
    t = t >>> sh;
    if (t > SAT_HI)      scale = SAT_HI[DW-1:0];
    else if (t < SAT_LO) scale = SAT_LO[DW-1:0];
    else                 scale = t[DW-1:0];
  endfunction

  logic [BV-1:0] s_next;

  always_comb begin
    s_next = '0;
    for (int unsigned n = 0; n < NUM_BANKS; n++)
      s_next[n*DW +: DW] = scale(m_g[n], m_shift, m_round);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grad_valid <= 1'b0;
      grad_data  <= '0;
      sample_cnt <= '0;
    end else begin
      grad_valid <= m_valid;
      if (m_valid) begin
        grad_data  <= s_next;
        sample_cnt <= sample_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_sgd_loss_gradient_unit.sv
// Directed bench for sgd_loss_gradient_unit: hand-computed vectors for each loss mode, scaling,
// saturation, join skew, FIFO overflow and mid-stream reset.
module tb_sgd_loss_gradient_unit;
  localparam int NB = 8;
  localparam int EN = 4;
  localparam int DW = 32;
  localparam int BV = NB * DW;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [4:0]          cfg_shift = '0;
  logic [1:0]          cfg_mode = '0;
  logic                cfg_round = 1'b0;
  logic [EN*BV-1:0]    dot_data = '0;
  logic [EN-1:0]       dot_valid = '0;
  logic [EN-1:0]       dot_almost_full;
  logic [BV-1:0]       b_data = '0;
  logic                b_wr_en = 1'b0;
  logic                b_almost_full;
  logic [BV-1:0]       grad_data;
  logic                grad_valid;
  logic [31:0]         sample_cnt;
  logic                err_overflow;

  int   vectors = 0;
  int   miscompares = 0;
  int   exp_cnt = 0;
  logic ramp = 1'b0;

  typedef struct {
    logic [1:0]  mode;
    logic [4:0]  sh;
    logic        rnd;
    logic [31:0] p0, p1, p2, p3, b, exp;
    string       name;
  } vec_t;

  sgd_loss_gradient_unit #(
    .NUM_BANKS(NB), .ENGINE_NUM(EN), .DW(DW), .FRAC(24), .FIFO_DEPTH_BITS(6), .AF_MARGIN(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_shift(cfg_shift), .cfg_mode(cfg_mode), .cfg_round(cfg_round),
    .dot_data(dot_data), .dot_valid(dot_valid), .dot_almost_full(dot_almost_full),
    .b_data(b_data), .b_wr_en(b_wr_en), .b_almost_full(b_almost_full),
    .grad_data(grad_data), .grad_valid(grad_valid), .sample_cnt(sample_cnt),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [BV-1:0] rep(input logic [31:0] v);
    rep = {NB{v}};
  endfunction

  // With ramp set, engine e bank n gets p[e] + n*(e+1) and bank n's label gets b + 3n
  task automatic put(input logic [EN-1:0] ev, input logic bw,
                     input logic [31:0] p0, p1, p2, p3, bv);
    logic [31:0] p [EN];
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    for (int e = 0; e < EN; e++)
      for (int n = 0; n < NB; n++)
        dot_data[(e*NB+n)*DW +: DW] = p[e] + (ramp ? 32'(n*(e+1)) : 32'd0);
    for (int n = 0; n < NB; n++)
      b_data[n*DW +: DW] = bv + (ramp ? 32'(n*3) : 32'd0);
    dot_valid = ev;
    b_wr_en   = bw;
  endtask

  task automatic idle();
    dot_valid = '0;
    b_wr_en   = 1'b0;
  endtask

  task automatic run_sample(input logic [1:0] mode, input logic [4:0] sh, input logic rnd,
                            input logic [31:0] p0, p1, p2, p3, bv,
                            output logic found, output logic [BV-1:0] val, output int lat);
    cfg_mode = mode; cfg_shift = sh; cfg_round = rnd;
    put(4'b1111, 1'b1, p0, p1, p2, p3, bv);
    @(negedge clk);
    idle();
    lat = 0;
    while (grad_valid !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    found = (grad_valid === 1'b1);
    val   = grad_data;
  endtask

  task automatic test_reset();
    vectors++; if (grad_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", grad_valid); end
    vectors++; if (grad_data !== '0) begin miscompares++; $display("FAIL reset_data: got %h expected 0", grad_data); end
    vectors++; if (sample_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d expected 0", sample_cnt); end
    vectors++; if (err_overflow !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", err_overflow); end
    vectors++; if ({dot_almost_full, b_almost_full} !== 5'b0) begin miscompares++; $display("FAIL reset_af: got %b expected 00000", {dot_almost_full, b_almost_full}); end
  endtask

  task automatic test_lsq();
    logic f; logic [BV-1:0] v, e; int lat;
    run_sample(2'd0, 5'd0, 1'b0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd4, f, v, lat); exp_cnt++;
    vectors++; if (lat != 6 || !f) begin miscompares++; $display("FAIL lsq_latency: got %0d cycles (found=%b) expected 6", lat, f); end
    vectors++; if (v !== rep(32'd6)) begin miscompares++; $display("FAIL lsq_value: got %h expected %h", v, rep(32'd6)); end
    @(negedge clk);
    vectors++; if (grad_valid !== 1'b0) begin miscompares++; $display("FAIL lsq_strobe: got %b expected 0", grad_valid); end
    vectors++; if (grad_data !== rep(32'd6)) begin miscompares++; $display("FAIL lsq_hold: got %h expected %h", grad_data, rep(32'd6)); end
    ramp = 1'b1;
    run_sample(2'd0, 5'd0, 1'b0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd4, f, v, lat); exp_cnt++;
    ramp = 1'b0;
    for (int n = 0; n < NB; n++) e[n*DW +: DW] = 32'(6 + 7*n);
    vectors++; if (!f || v !== e) begin miscompares++; $display("FAIL lsq_banks: found=%b got %h expected %h", f, v, e); end
    vectors++; if (sample_cnt !== 32'(exp_cnt)) begin miscompares++; $display("FAIL lsq_cnt: got %0d expected %0d", sample_cnt, exp_cnt); end
  endtask

  task automatic test_scaling();
    vec_t tv [11];
    logic f; logic [BV-1:0] v; int lat;
    tv[0]  = '{2'd0, 5'd1, 1'b0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFC, "shift_trunc_neg"};
    tv[1]  = '{2'd0, 5'd1, 1'b1, 32'd0, 32'd0, 32'd0, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFD, "shift_round_neg"};
    tv[2]  = '{2'd0, 5'd1, 1'b1, 32'd0, 32'd0, 32'd3, 32'd2, 32'd0, 32'd3, "shift_round_pos"};
    tv[3]  = '{2'd3, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, "mode_reserved"};
    tv[4]  = '{2'd0, 5'd0, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, "sat_high"};
    tv[5]  = '{2'd0, 5'd0, 1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'd1, 32'h80000000, "sat_low"};
    tv[6]  = '{2'd0, 5'd3, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h3FFFFFFF, "wide_trunc"};
    tv[7]  = '{2'd0, 5'd3, 1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h40000000, "wide_round"};
    tv[8]  = '{2'd2, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd5, 32'd0, 32'h01000000, "l1_pos"};
    tv[9]  = '{2'd2, 5'd24, 1'b0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFD, 32'd0, 32'hFFFFFFFF, "l1_neg_shift"};
    tv[10] = '{2'd2, 5'd0, 1'b0, 32'd2, 32'd0, 32'd0, 32'd0, 32'd2, 32'd0, "l1_zero"};
    for (int i = 0; i < 11; i++) begin
      run_sample(tv[i].mode, tv[i].sh, tv[i].rnd, tv[i].p0, tv[i].p1, tv[i].p2, tv[i].p3, tv[i].b, f, v, lat);
      exp_cnt++;
      vectors++; if (!f || v !== rep(tv[i].exp)) begin miscompares++; $display("FAIL %s: found=%b got %h expected %h", tv[i].name, f, v[31:0], tv[i].exp); end
    end
  endtask

  task automatic test_hinge();
    vec_t tv [4];
    logic f; logic [BV-1:0] v; int lat;
    tv[0] = '{2'd1, 5'd0, 1'b0, 32'h00200000, 32'h00200000, 32'h00200000, 32'h00200000, 32'h01000000, 32'hFF000000, "hinge_inside"};
    tv[1] = '{2'd1, 5'd0, 1'b0, 32'h00800000, 32'h00800000, 32'h00800000, 32'h00800000, 32'h01000000, 32'd0, "hinge_outside"};
    tv[2] = '{2'd1, 5'd0, 1'b0, 32'hFF800000, 32'hFF800000, 32'hFF800000, 32'hFF800000, 32'hFF000000, 32'd0, "hinge_neg_label"};
    tv[3] = '{2'd1, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFF000000, 32'h01000000, "hinge_neg_inside"};
    for (int i = 0; i < 4; i++) begin
      run_sample(tv[i].mode, tv[i].sh, tv[i].rnd, tv[i].p0, tv[i].p1, tv[i].p2, tv[i].p3, tv[i].b, f, v, lat);
      exp_cnt++;
      vectors++; if (!f || v !== rep(tv[i].exp)) begin miscompares++; $display("FAIL %s: found=%b got %h expected %h", tv[i].name, f, v[31:0], tv[i].exp); end
    end
  endtask

  task automatic test_join_skew();
    logic [BV-1:0] got [3];
    int   n_got = 0;
    logic early = 1'b0;
    cfg_mode = 2'd0; cfg_shift = 5'd0; cfg_round = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      put(4'b0111, 1'b1, 32'(k), 32'(k), 32'(k), 32'd0, 32'd0);
      @(negedge clk);
    end
    idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (grad_valid !== 1'b0) early = 1'b1;
    end
    vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL join_wait: got early grad_valid expected none"); end
    for (int k = 1; k <= 3; k++) begin
      put(4'b1000, 1'b0, 32'd0, 32'd0, 32'd0, 32'(10*k), 32'd0);
      @(negedge clk);
    end
    idle();
    for (int i = 0; i < 20; i++) begin
      if (grad_valid === 1'b1) begin
        if (n_got < 3) got[n_got] = grad_data;
        n_got++;
      end
      @(negedge clk);
    end
    exp_cnt += 3;
    vectors++; if (n_got != 3) begin miscompares++; $display("FAIL join_count: got %0d outputs expected 3", n_got); end
    for (int k = 0; k < 3 && k < n_got; k++) begin
      vectors++; if (got[k] !== rep(32'(13*(k+1)))) begin miscompares++; $display("FAIL join_order%0d: got %h expected %h", k, got[k][31:0], 32'(13*(k+1))); end
    end
    vectors++; if (sample_cnt !== 32'(exp_cnt)) begin miscompares++; $display("FAIL join_cnt: got %0d expected %0d", sample_cnt, exp_cnt); end
  endtask

  task automatic test_overflow();
    int   n_got = 0;
    logic in_order = 1'b1;
    cfg_mode = 2'd0; cfg_shift = 5'd0; cfg_round = 1'b0;
    for (int i = 1; i <= 65; i++) begin
      put(4'b0001, 1'b0, 32'(i), 32'd0, 32'd0, 32'd0, 32'd0);
      @(negedge clk);
      if (i == 55) begin
        vectors++; if (dot_almost_full !== 4'b0000) begin miscompares++; $display("FAIL af_below: got %b expected 0000", dot_almost_full); end
      end
      if (i == 56) begin
        vectors++; if (dot_almost_full !== 4'b0001) begin miscompares++; $display("FAIL af_at: got %b expected 0001", dot_almost_full); end
      end
      if (i == 64) begin
        vectors++; if (err_overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_early: got %b expected 0", err_overflow); end
      end
      if (i == 65) begin
        vectors++; if (err_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b expected 1", err_overflow); end
      end
    end
    idle();
    for (int c = 0; c < 90; c++) begin
      if (c < 64) put(4'b1110, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      else idle();
      @(negedge clk);
      if (grad_valid === 1'b1) begin
        if (grad_data !== rep(32'(n_got + 1))) in_order = 1'b0;
        n_got++;
      end
    end
    idle();
    exp_cnt += 64;
    vectors++; if (n_got != 64) begin miscompares++; $display("FAIL ovf_drop: got %0d outputs expected 64", n_got); end
    vectors++; if (in_order !== 1'b1) begin miscompares++; $display("FAIL ovf_order: got out-of-order data expected 1..64"); end
    vectors++; if (err_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b expected 1", err_overflow); end
    vectors++; if (sample_cnt !== 32'(exp_cnt)) begin miscompares++; $display("FAIL ovf_cnt: got %0d expected %0d", sample_cnt, exp_cnt); end
  endtask

  task automatic test_reset_midstream();
    logic f; logic [BV-1:0] v; int lat;
    logic leaked = 1'b0;
    cfg_mode = 2'd0; cfg_shift = 5'd0; cfg_round = 1'b0;
    put(4'b0001, 1'b0, 32'd99, 32'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    put(4'b1111, 1'b1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd0);
    @(negedge clk);
    put(4'b1111, 1'b1, 32'd2, 32'd2, 32'd2, 32'd2, 32'd0);
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (grad_valid !== 1'b0) leaked = 1'b1;
      @(negedge clk);
    end
    exp_cnt = 0;
    vectors++; if (leaked !== 1'b0) begin miscompares++; $display("FAIL rst_flush_valid: got grad_valid after reset expected none"); end
    vectors++; if (sample_cnt !== 32'd0) begin miscompares++; $display("FAIL rst_cnt: got %0d expected 0", sample_cnt); end
    vectors++; if (err_overflow !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b expected 0", err_overflow); end
    vectors++; if (grad_data !== '0) begin miscompares++; $display("FAIL rst_data: got %h expected 0", grad_data[31:0]); end
    run_sample(2'd0, 5'd0, 1'b0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, f, v, lat); exp_cnt++;
    vectors++; if (!f || v !== rep(32'd3)) begin miscompares++; $display("FAIL rst_fifo_empty: found=%b got %h expected %h", f, v[31:0], 32'd3); end
    vectors++; if (sample_cnt !== 32'(exp_cnt)) begin miscompares++; $display("FAIL rst_cnt_after: got %0d expected %0d", sample_cnt, exp_cnt); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_lsq();
    test_scaling();
    test_hinge();
    test_join_skew();
    test_overflow();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
